// File: rtl/dense_mac_sequencer_if.sv
// Bus bundle for dense_mac_sequencer: layer control, weight/input RAM ports and result stream.
// master = sequencer side, slave = controller / RAM / consumer side.
interface dense_mac_sequencer_if #(
  parameter int unsigned M     = 3,
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned WA_W = ($clog2(M * N) > 0) ? $clog2(M * N) : 1;
  localparam int unsigned XA_W = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int unsigned RI_W = ($clog2(M) > 0) ? $clog2(M) : 1;

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    w_rd_en;
  logic [WA_W-1:0]         w_addr;
  logic signed [WIDTH-1:0] w_data;
  logic [XA_W-1:0]         x_addr;
  logic signed [WIDTH-1:0] x_data;
  logic                    res_valid;
  logic                    res_ready;
  logic [RI_W-1:0]         res_idx;
  logic signed [WIDTH-1:0] res_data;

  modport master (
    input  start, w_data, x_data, res_ready,
    output busy, done, w_rd_en, w_addr, x_addr, res_valid, res_idx, res_data
  );

  modport slave (
    output start, w_data, x_data, res_ready,
    input  busy, done, w_rd_en, w_addr, x_addr, res_valid, res_idx, res_data
  );
endinterface

// File: rtl/dense_mac_sequencer.sv
// Time-multiplexed dense layer: res[m] = sat((sum_n W[m][n]*x[n]) >>> FRAC) with one signed MAC,
// streaming W/x from 1-cycle-latency RAMs.
// Build option: define RELU_EN to clamp negative results to zero (fused ReLU for hidden layers).
module dense_mac_sequencer #(
  parameter int unsigned M     = 3,
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  dense_mac_sequencer_if.master  io
);

  localparam int unsigned WA_W   = ($clog2(M * N) > 0) ? $clog2(M * N) : 1;
  localparam int unsigned XA_W   = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int unsigned RI_W   = ($clog2(M) > 0) ? $clog2(M) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned ACC_W  = 2 * WIDTH + $clog2(N) + 1;

  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [RI_W-1:0]         m_q, m_d;
  logic [XA_W-1:0]         n_q, n_d;
  logic [WA_W-1:0]         waddr_q, waddr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    pv_q, pv_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    w_rd_en_q, w_rd_en_d;
  logic                    res_valid_q, res_valid_d;
  logic signed [WIDTH-1:0] res_data_q, res_data_d;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc_sum_c;
  logic signed [ACC_W-1:0]  scaled_c;
  logic signed [WIDTH-1:0]  sat_c;

  // MAC datapath: accumulate the product of RAM data whenever last cycle issued a read.
  always_comb begin
    prod_c    = PROD_W'(io.w_data) * PROD_W'(io.x_data);
    acc_sum_c = acc_q + (pv_q ? ACC_W'(prod_c) : ACC_ZERO);
  end

  // Scale (arithmetic shift, floor), saturate to WIDTH, optional ReLU.
  always_comb begin
    scaled_c = acc_sum_c >>> FRAC;
    if (scaled_c > SAT_MAX) begin
      sat_c = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (scaled_c < SAT_MIN) begin
      sat_c = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat_c = scaled_c[WIDTH-1:0];
    end
`ifdef RELU_EN
    if (sat_c[WIDTH-1]) begin
      sat_c = '0;
    end
`else
`endif
  end

  // Next-state, counters and registered-output targets.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    waddr_d    = waddr_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    pv_d       = w_rd_en_q;

    unique case (state_q)
      S_IDLE: begin
        if (io.start) begin
          state_d = S_FETCH;
          m_d     = '0;
          n_d     = '0;
          waddr_d = '0;
          acc_d   = '0;
        end
      end
      S_FETCH: begin
        acc_d = acc_sum_c;
        if (n_q == XA_W'(N - 1)) begin
          state_d = S_DRAIN;
        end else begin
          n_d     = n_q + XA_W'(1);
          waddr_d = waddr_q + WA_W'(1);
        end
      end
      S_DRAIN: begin
        acc_d      = acc_sum_c;
        res_data_d = sat_c;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (io.res_ready) begin
          if (m_q == RI_W'(M - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            m_d     = m_q + RI_W'(1);
            n_d     = '0;
            waddr_d = waddr_q + WA_W'(1);
            acc_d   = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    w_rd_en_d   = (state_d == S_FETCH);
    res_valid_d = (state_d == S_WRITE);
  end

  // State and output registers; synchronous reset aborts any layer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      n_q         <= '0;
      waddr_q     <= '0;
      acc_q       <= '0;
      pv_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_rd_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      waddr_q     <= waddr_d;
      acc_q       <= acc_d;
      pv_q        <= pv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      w_rd_en_q   <= w_rd_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.w_rd_en   = w_rd_en_q;
  assign io.w_addr    = waddr_q;
  assign io.x_addr    = n_q;
  assign io.res_valid = res_valid_q;
  assign io.res_idx   = m_q;
  assign io.res_data  = res_data_q;

endmodule
